// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H synchronous 245 FIFO RX/TX blocks.
//   BUS_W   : ADBUS width in bits
//   state_e : bus sequencing states (IDLE, ARM turnaround, READ)
package ft2232h_pkg;

  localparam int unsigned BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    READ = 2'd2
  } state_e;

endpackage

// File: rtl/ft2232h_rx_fifo.sv
// First-word-fall-through synchronous FIFO for captured RX bytes.
//   clk, reset_n : clock, async active-low reset (pointers and count only)
//   push, data   : write strobe and byte
//   pop          : consume head; ignored when empty
//   head         : current head byte, forced to 0 while empty
//   count        : occupancy, 0..DEPTH
module ft2232h_rx_fifo
  import ft2232h_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [BUS_W-1:0]             data,
  input  logic                         pop,
  output logic [BUS_W-1:0]             head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != CNT_W'(DEPTH)) | pop_ok);

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/ft2232h_rx.sv
// FT2232H sync-245 receive controller: sequences OE#/RD# against RXF# and
// drains bytes into an FWFT buffer with a valid/ready output.
//   clk, reset_n          : 60 MHz CLKOUT, async active-low reset
//   rxf_n, data_in        : FTDI data-available flag and ADBUS read path
//   oe_n, rd_n            : FTDI output-enable and read strobe (registered)
//   out_data, out_valid   : buffer head and non-empty flag
//   out_ready             : consumer accepts head this cycle
module ft2232h_rx
  import ft2232h_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rxf_n,
  input  logic [BUS_W-1:0] data_in,
  output logic             oe_n,
  output logic             rd_n,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e           state;
  state_e           state_d;
  logic             oe_d;
  logic             rd_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push_c;
  logic             pop_c;
  logic             space_c;

  // A byte moves only when RD# was low and the chip still flagged data.
  assign push_c     = (state == READ) & ~rd_n & ~rxf_n;
  assign pop_c      = out_valid & out_ready;
  assign count_next = count + CNT_W'(push_c) - CNT_W'(pop_c);
  // Look-ahead: RD# for the next edge only if a slot remains after this one.
  assign space_c    = count_next < CNT_W'(DEPTH);

  assign out_valid  = (count != '0);

  ft2232h_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_c),
    .data    (data_in),
    .pop     (pop_c),
    .head    (out_data),
    .count   (count)
  );

  // State and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      oe_n  <= 1'b1;
      rd_n  <= 1'b1;
    end else begin
      state <= state_d;
      oe_n  <= oe_d;
      rd_n  <= rd_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state;
    oe_d    = oe_n;
    rd_d    = rd_n;
    unique case (state)
      IDLE: begin
        oe_d = 1'b1;
        rd_d = 1'b1;
        if (~rxf_n & space_c) begin
          state_d = ARM;
          oe_d    = 1'b0;
        end
      end
      ARM: begin
        // Turnaround cycle: FTDI starts driving the bus, no read yet.
        if (rxf_n) begin
          state_d = IDLE;
          oe_d    = 1'b1;
          rd_d    = 1'b1;
        end else begin
          state_d = READ;
          rd_d    = ~space_c;
        end
      end
      READ: begin
        if (rxf_n) begin
          state_d = IDLE;
          oe_d    = 1'b1;
          rd_d    = 1'b1;
        end else begin
          rd_d = ~space_c;
        end
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b1;
        rd_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ft2232h_rx.sv
// Self-checking bench for ft2232h_rx: an FTDI byte-source model and a
// queue-based buffer model checked against the DUT every cycle.
module tb_ft2232h_rx;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxf_n;
  logic [7:0] data_in;
  logic       oe_n;
  logic       rd_n;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q[$];   // bytes the FTDI chip still holds
  logic [7:0] exp_q[$];   // bytes the buffer should hold
  logic [7:0] got_q[$];   // bytes the DUT actually handed to the consumer
  logic [7:0] stream[$];  // reference stream for the current test
  logic       xfer_pend = 1'b0;
  logic       pop_pend  = 1'b0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_head  = 8'h00;
  bit         mon_en    = 1'b0;

  ft2232h_rx #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxf_n     (rxf_n),
    .data_in   (data_in),
    .oe_n      (oe_n),
    .rd_n      (rd_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // RD# must never be asserted while the FTDI is not driving the bus.
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (!rd_n && oe_n) begin
        n_fail++;
        $display("FAIL rd_without_oe: rd_n=%b oe_n=%b, rd_n low requires oe_n low", rd_n, oe_n);
      end
    end
  end

  // Set inputs for the coming edge and note what that edge will transfer.
  task automatic drive(input logic ready, input logic hold_high);
    out_ready = ready;
    rxf_n     = hold_high || (src_q.size() == 0);
    data_in   = rxf_n ? 8'($urandom) : src_q[0];
    xfer_pend = !rd_n && !rxf_n;
    pop_pend  = ready && (exp_q.size() != 0);
    if (pop_pend) got_q.push_back(out_data);
  endtask

  // Advance past the edge to the next negedge and update the models.
  task automatic tick();
    @(negedge clk);
    if (xfer_pend) exp_q.push_back(src_q.pop_front());
    if (pop_pend) void'(exp_q.pop_front());
    exp_valid = (exp_q.size() != 0);
    exp_head  = exp_valid ? exp_q[0] : 8'h00;
    xfer_pend = 1'b0;
    pop_pend  = 1'b0;
  endtask

  task automatic load_stream();
    src_q.delete();
    got_q.delete();
    foreach (stream[i]) src_q.push_back(stream[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rxf_n = 1'b1; out_ready = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    n_tests++;
    if (oe_n !== 1'b1 || rd_n !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: oe_n=%b rd_n=%b valid=%b data=%h, required 1 1 0 00", oe_n, rd_n, out_valid, out_data);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1);
      tick();
      n_tests++;
      if (oe_n !== 1'b1 || rd_n !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: cyc=%0d oe_n=%b rd_n=%b valid=%b, required 1 1 0", c, oe_n, rd_n, out_valid);
      end
    end
  endtask

  task automatic test_basic();
    int first = -1;
    int last  = -1;
    logic prev_rxf;
    stream = '{8'h10, 8'h11, 8'h12, 8'h13};
    load_stream();
    drive(1'b1, 1'b0); tick();
    n_tests++;
    if (oe_n !== 1'b0 || rd_n !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_edge1: oe_n=%b rd_n=%b, required 0 1", oe_n, rd_n);
    end
    drive(1'b1, 1'b0); tick();
    n_tests++;
    if (oe_n !== 1'b0 || rd_n !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_edge2: oe_n=%b rd_n=%b, required 0 0", oe_n, rd_n);
    end
    prev_rxf = rxf_n;
    for (int c = 0; c < 20 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      drive(1'b1, 1'b0);
      if (pop_pend) begin
        if (first < 0) first = c;
        last = c;
      end
      tick();
      n_tests++;
      if (out_valid !== exp_valid || out_data !== exp_head) begin
        n_fail++;
        $display("FAIL basic_sb: valid=%b data=%h, required %b %h", out_valid, out_data, exp_valid, exp_head);
      end
      if (rxf_n && !prev_rxf) begin
        n_tests++;
        if (oe_n !== 1'b1 || rd_n !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_release: oe_n=%b rd_n=%b, required 1 1", oe_n, rd_n);
        end
      end
      prev_rxf = rxf_n;
    end
    n_tests++;
    if (got_q.size() != 4 || last - first != 3) begin
      n_fail++;
      $display("FAIL basic_consecutive: got %0d bytes over %0d cycles, required 4 over 4", got_q.size(), last - first + 1);
    end
    foreach (got_q[i]) begin
      n_tests++;
      if (got_q[i] !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL basic_order: idx=%0d got=%h required=%h", i, got_q[i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_full();
    stream.delete();
    for (int i = 0; i < 12; i++) stream.push_back(8'(i));
    load_stream();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b0);
      tick();
      n_tests++;
      if (out_valid !== exp_valid || out_data !== exp_head || (!rd_n && exp_q.size() >= DEPTH)) begin
        n_fail++;
        $display("FAIL full_sb: valid=%b data=%h rd_n=%b held=%0d, required %b %h", out_valid, out_data, rd_n, exp_q.size(), exp_valid, exp_head);
      end
    end
    n_tests++;
    if (src_q.size() != 4 || rd_n !== 1'b1 || oe_n !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL full_stall: captured=%0d rd_n=%b oe_n=%b head=%h, required 8 1 0 00", 12 - src_q.size(), rd_n, oe_n, out_data);
    end
    for (int c = 0; c < 60 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      drive(1'b1, 1'b0);
      tick();
      n_tests++;
      if (out_valid !== exp_valid || out_data !== exp_head || (!rd_n && exp_q.size() >= DEPTH)) begin
        n_fail++;
        $display("FAIL full_drain_sb: valid=%b data=%h rd_n=%b, required %b %h", out_valid, out_data, rd_n, exp_valid, exp_head);
      end
    end
    n_tests++;
    if (got_q.size() != 12) begin
      n_fail++;
      $display("FAIL full_count: got %0d bytes, required 12", got_q.size());
    end
    foreach (got_q[i]) begin
      n_tests++;
      if (got_q[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL full_order: idx=%0d got=%h required=%h", i, got_q[i], 8'(i));
      end
    end
  endtask

  // mode 0: out_ready toggles every cycle; mode 1: random ready and RXF# gaps.
  task automatic test_stream(input int mode, input int len);
    logic ready;
    logic hold;
    stream.delete();
    for (int i = 0; i < len; i++) stream.push_back(mode == 0 ? 8'(8'hA0 + i) : 8'($urandom));
    load_stream();
    for (int c = 0; c < 1500 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      ready = (mode == 0) ? 1'(c % 2) : 1'($urandom_range(0, 1));
      hold  = (mode == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
      drive(ready, hold);
      tick();
      n_tests++;
      if (out_valid !== exp_valid || out_data !== exp_head || (!rd_n && exp_q.size() >= DEPTH)) begin
        n_fail++;
        $display("FAIL stream%0d_sb: cyc=%0d valid=%b data=%h rd_n=%b, required %b %h", mode, c, out_valid, out_data, rd_n, exp_valid, exp_head);
      end
    end
    n_tests++;
    if (got_q.size() != len) begin
      n_fail++;
      $display("FAIL stream%0d_count: got %0d bytes, required %0d", mode, got_q.size(), len);
    end
    foreach (got_q[i]) begin
      n_tests++;
      if (i < len && got_q[i] !== stream[i]) begin
        n_fail++;
        $display("FAIL stream%0d_order: idx=%0d got=%h required=%h", mode, i, got_q[i], stream[i]);
      end
    end
  endtask

  task automatic test_rxf_glitch();
    stream.delete();
    for (int i = 0; i < 10; i++) stream.push_back(8'($urandom));
    load_stream();
    repeat (4) begin
      drive(1'b1, 1'b0); tick();
    end
    drive(1'b1, 1'b1); tick();
    n_tests++;
    if (oe_n !== 1'b1 || rd_n !== 1'b1 || out_valid !== exp_valid || out_data !== exp_head) begin
      n_fail++;
      $display("FAIL glitch_idle: oe_n=%b rd_n=%b valid=%b data=%h, required 1 1 %b %h", oe_n, rd_n, out_valid, out_data, exp_valid, exp_head);
    end
    drive(1'b1, 1'b0); tick();
    n_tests++;
    if (oe_n !== 1'b0 || rd_n !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_arm: oe_n=%b rd_n=%b, required 0 1", oe_n, rd_n);
    end
    drive(1'b1, 1'b0); tick();
    n_tests++;
    if (oe_n !== 1'b0 || rd_n !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_read: oe_n=%b rd_n=%b, required 0 0", oe_n, rd_n);
    end
    for (int c = 0; c < 40 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      drive(1'b1, 1'b0);
      tick();
      n_tests++;
      if (out_valid !== exp_valid || out_data !== exp_head) begin
        n_fail++;
        $display("FAIL glitch_sb: valid=%b data=%h, required %b %h", out_valid, out_data, exp_valid, exp_head);
      end
    end
    n_tests++;
    if (got_q.size() != 10) begin
      n_fail++;
      $display("FAIL glitch_count: got %0d bytes, required 10", got_q.size());
    end
    foreach (got_q[i]) begin
      n_tests++;
      if (i < 10 && got_q[i] !== stream[i]) begin
        n_fail++;
        $display("FAIL glitch_order: idx=%0d got=%h required=%h", i, got_q[i], stream[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    stream.delete();
    for (int i = 0; i < 6; i++) stream.push_back(8'($urandom));
    load_stream();
    for (int c = 0; c < 20 && exp_q.size() < 3; c++) begin
      drive(1'b0, 1'b0);
      tick();
    end
    n_tests++;
    if (exp_q.size() != 3 || out_valid !== 1'b1 || out_data !== exp_head) begin
      n_fail++;
      $display("FAIL areset_fill: held=%0d valid=%b data=%h, required 3 1 %h", exp_q.size(), out_valid, out_data, exp_head);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (oe_n !== 1'b1 || rd_n !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_async: oe_n=%b rd_n=%b valid=%b data=%h, required 1 1 0 00", oe_n, rd_n, out_valid, out_data);
    end
    exp_q.delete();
    exp_valid = 1'b0;
    exp_head  = 8'h00;
    rxf_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
    load_stream();
    for (int c = 0; c < 30 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      drive(1'b1, 1'b0);
      tick();
      n_tests++;
      if (out_valid !== exp_valid || out_data !== exp_head) begin
        n_fail++;
        $display("FAIL areset_sb: valid=%b data=%h, required %b %h", out_valid, out_data, exp_valid, exp_head);
      end
    end
    n_tests++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL areset_count: got %0d bytes, required 4", got_q.size());
    end
    foreach (got_q[i]) begin
      n_tests++;
      if (i < 4 && got_q[i] !== stream[i]) begin
        n_fail++;
        $display("FAIL areset_order: idx=%0d got=%h required=%h", i, got_q[i], stream[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream(0, 40);
    test_rxf_glitch();
    test_stream(1, 80);
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
